pool_window_buffer: RTL and testbench
=====================================

Name: pool_window_buffer

Overview:
- Raster-to-window converter that sits directly upstream of the average-pool stage.
- Accepts one spatial pixel per beat (all NFMAPS channels in parallel) in row-major order.
- Buffers KER_SIZE-1 rows and emits one complete non-overlapping KER_SIZE x KER_SIZE window per channel, in the packed layout the pool stage consumes, with a single-cycle valid.
- Stride equals KER_SIZE. No backpressure: the pool stage always accepts.

Parameters:
- NBITS, 32, activation width in bits.
- NFMAPS, 32, number of feature maps (channels) per pixel.
- KER_SIZE, 2, window edge and stride; supported range 2..7.
- IMG_W, 8, frame width in pixels; must be a multiple of KER_SIZE.
- IMG_H, 8, frame height in pixels; must be a multiple of KER_SIZE.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- clear  input  1  synchronous restart of the frame position; takes priority over in_valid.
- in_valid  input  1  in_act carries a pixel this cycle; every in_valid beat is consumed.
- in_act  input  NBITS*NFMAPS  one pixel; channel f at bits [(f+1)*NBITS-1 : f*NBITS].
- out_valid  output  1  window present on out_act; single-cycle pulse.
- out_act  output  [NBITS*KER_SIZE*KER_SIZE-1:0] x [NFMAPS-1:0]  one packed window per channel (unpacked array).
- frame_done  output  1  pulses together with the last window of a frame.

Behaviour:
- Reset (rstn low, asynchronous): col=0, row=0, out_valid=0, frame_done=0, out_act='0. Line-buffer contents are don't-care and are never emitted before being rewritten.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance only on in_valid.
  - col wraps to 0 and row increments.
  - At col=IMG_W-1 and row=IMG_H-1, both wrap to 0; the next beat is pixel (0,0) of the next frame.
- Line buffer: KER_SIZE-1 row stores of IMG_W pixels each. A pixel with r = row mod KER_SIZE < KER_SIZE-1 is written to store r at address col.
- Current-row shift register: KER_SIZE-1 pixels deep, loaded on every in_valid.
- Window emit condition: in_valid AND (row mod K == K-1) AND (col mod K == K-1).
- Window assembly (K = KER_SIZE):
  - Element (i,j), with i,j in 0..K-1, takes pixel (row-K+1+i, col-K+1+j).
  - Rows i < K-1 come from line store i.
  - Row K-1 comes from the shift register, with the incoming pixel as j=K-1.
  - Element index e = i*K + j, placed at out_act[f][(e+1)*NBITS-1 : e*NBITS].
- Latency: out_act and out_valid are registered. out_valid is high exactly in the cycle after the emitting beat.
- out_act holds its value until the next emit; it is not cleared between windows.
- frame_done: registered, and asserted in the same cycle as out_valid for the window ending at (IMG_H-1, IMG_W-1).
- Throughput: one window per K beats at best. Consecutive emits are never closer than K cycles.
- in_valid gaps (bubbles): allowed anywhere. State freezes and the window content is unaffected.
- clear:
  - Counters return to 0 next cycle and out_valid/frame_done go 0.
  - A beat presented with clear is dropped.
  - A partially filled window is discarded.
  - clear and rstn both restart mid-frame with identical position semantics.
- Arithmetic: none; pure data movement. No sign handling.

Decomposition:
- Shared package pool_pkg holds:
  - localparam WIN_ELEMS = KER_SIZE*KER_SIZE;
  - a function returning the element bit offset e*NBITS;
  - the counter width clog2(IMG_W) / clog2(IMG_H) helpers, reused by the pool stage and its bench.
- One sub-module, pool_line_store: a single-row store of IMG_W x (NBITS*NFMAPS) with one write port and combinational read by address. Instantiate KER_SIZE-1 copies.
- Elaboration-time assertions: IMG_W % KER_SIZE == 0, IMG_H % KER_SIZE == 0, KER_SIZE >= 2.

Test Plan:
- Basic window: NBITS=8, NFMAPS=2, K=2, IMG_W=IMG_H=4; fmap0 pixel (r,c)=r*4+c, fmap1 = that +100; stream 16 beats back-to-back.
  - out_valid at cycles 6, 8, 14, 16 (1-based).
  - First window: out_act[0]={8'd5,8'd4,8'd1,8'd0}, out_act[1]={105,104,101,100}.
  - frame_done only with the window {15,14,11,10}.
- Bubbles: same frame with in_valid low every other cycle -> identical 4 windows and values, each out_valid one cycle after its beat (6, 8, 14, 16).
- Back-to-back frames: 32 beats continuous -> 8 windows; windows 5-8 repeat the frame-1 values; frame_done twice.
- clear mid-frame: assert clear after beat 6 (first window already emitted), then restart the frame from pixel (0,0) -> next window is {5,4,1,0}, with no spurious out_valid.
- Async reset mid-window: drop rstn for 1 cycle after beat 5 -> out_valid, frame_done and out_act go 0 immediately; the full frame replayed afterwards yields the basic-window results.
- K=7, NBITS=16, NFMAPS=1, IMG_W=IMG_H=7, pixel = r*7+c -> single out_valid after beat 49; element e equals e (0..48) and frame_done asserts with it.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared constants and helpers for the average-pool window path.
// Element offsets and counter widths are reused by the pool stage and its bench.
package pool_pkg;

    localparam int DEF_NBITS    = 32;
    localparam int DEF_NFMAPS   = 32;
    localparam int DEF_KER_SIZE = 2;
    localparam int DEF_IMG_W    = 8;
    localparam int DEF_IMG_H    = 8;

    localparam int WIN_ELEMS = DEF_KER_SIZE * DEF_KER_SIZE;

    function automatic int elem_off(input int e, input int nbits);
        return e * nbits;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int col_w(input int img_w);
        return cnt_w(img_w);
    endfunction

    function automatic int row_w(input int img_h);
        return cnt_w(img_h);
    endfunction

endpackage

// File: rtl/pool_line_store.sv
// One image row of pixels: single write port, NRD combinational read ports.
// Contents are not reset; rows are always rewritten before being read.
module pool_line_store
    import pool_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int NRD   = 2,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i [NRD],
    output logic [W-1:0]  rdata_o [NRD]
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        assign rdata_o[p] = mem_q[raddr_i[p]];
    end

endmodule

// File: rtl/pool_window_buffer.sv
// Raster-to-window converter feeding the average-pool stage.
// Emits one non-overlapping KER_SIZE x KER_SIZE window per channel.
module pool_window_buffer
    import pool_pkg::*;
#(
    parameter int NBITS    = DEF_NBITS,
    parameter int NFMAPS   = DEF_NFMAPS,
    parameter int KER_SIZE = DEF_KER_SIZE,
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic in_valid,
    input  logic [NBITS*NFMAPS-1:0] in_act,
    output logic out_valid,
    output logic [NBITS*KER_SIZE*KER_SIZE-1:0] out_act [NFMAPS],
    output logic frame_done
);

    localparam int K   = KER_SIZE;
    localparam int WIN = K * K;
    localparam int PW  = NBITS * NFMAPS;
    localparam int CW  = col_w(IMG_W);
    localparam int RW  = row_w(IMG_H);
    localparam int KW  = cnt_w(K);

    if (K < 2) begin : g_chk_k
        $error("KER_SIZE must be at least 2");
    end
    if (IMG_W % K != 0) begin : g_chk_w
        $error("IMG_W must be a multiple of KER_SIZE");
    end
    if (IMG_H % K != 0) begin : g_chk_h
        $error("IMG_H must be a multiple of KER_SIZE");
    end

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [KW-1:0] ck_q, ck_d;
    logic [KW-1:0] rk_q, rk_d;
    logic          out_valid_q;
    logic          frame_done_q;
    logic [NBITS*WIN-1:0] out_act_q [NFMAPS];
    logic [NBITS*WIN-1:0] win_d [NFMAPS];
    logic [PW-1:0] sr_q [K-1];
    logic [PW-1:0] rd [(K-1)*K];
    logic [CW-1:0] ra [K];

    logic beat, emit;
    logic col_last, row_last, ck_last, rk_last;

    assign beat     = in_valid & ~clear;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign ck_last  = (ck_q == KW'(K - 1));
    assign rk_last  = (rk_q == KW'(K - 1));
    assign emit     = beat & ck_last & rk_last;

    // ck/rk track col/row mod K so no divider is needed
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        ck_d  = ck_q;
        rk_d  = rk_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
            ck_d  = '0;
            rk_d  = '0;
        end else if (in_valid) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            ck_d  = ck_last ? '0 : ck_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
                rk_d  = rk_last ? '0 : rk_q + 1'b1;
            end
        end
    end

    // Window columns start at col - (col mod K), always in range
    for (genvar j = 0; j < K; j++) begin : g_ra
        assign ra[j] = col_q - CW'(ck_q) + CW'(j);
    end

    for (genvar i = 0; i < K - 1; i++) begin : g_row
        logic          we;
        logic [PW-1:0] rdl [K];

        assign we = beat && (rk_q == KW'(i));

        pool_line_store #(
            .W     (PW),
            .DEPTH (IMG_W),
            .NRD   (K),
            .AW    (CW)
        ) u_store (
            .clk_i   (clk),
            .we_i    (we),
            .waddr_i (col_q),
            .wdata_i (in_act),
            .raddr_i (ra),
            .rdata_o (rdl)
        );

        for (genvar j = 0; j < K; j++) begin : g_rdm
            assign rd[i*K+j] = rdl[j];
        end
    end

    always_comb begin
        for (int f = 0; f < NFMAPS; f++) begin
            win_d[f] = '0;
        end
        for (int i = 0; i < K - 1; i++) begin
            for (int j = 0; j < K; j++) begin
                for (int f = 0; f < NFMAPS; f++) begin
                    win_d[f][elem_off(i*K+j, NBITS) +: NBITS] =
                        rd[i*K+j][f*NBITS +: NBITS];
                end
            end
        end
        for (int j = 0; j < K - 1; j++) begin
            for (int f = 0; f < NFMAPS; f++) begin
                win_d[f][elem_off((K-1)*K+j, NBITS) +: NBITS] =
                    sr_q[j][f*NBITS +: NBITS];
            end
        end
        for (int f = 0; f < NFMAPS; f++) begin
            win_d[f][elem_off(WIN-1, NBITS) +: NBITS] =
                in_act[f*NBITS +: NBITS];
        end
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            for (int j = 0; j < K - 2; j++) begin
                sr_q[j] <= sr_q[j+1];
            end
            sr_q[K-2] <= in_act;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q        <= '0;
            row_q        <= '0;
            ck_q         <= '0;
            rk_q         <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int f = 0; f < NFMAPS; f++) begin
                out_act_q[f] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            ck_q         <= ck_d;
            rk_q         <= rk_d;
            out_valid_q  <= emit;
            frame_done_q <= emit & row_last & col_last;
            if (emit) begin
                out_act_q <= win_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign out_act    = out_act_q;

endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed bench: 4x4 K=2 two-channel frames plus a 7x7 K=7 single window.
// Expected windows are hand-computed constants.
module tb_pool_window_buffer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_act;
    logic        out_valid;
    logic        frame_done;
    logic [31:0] out_act [2];

    logic         clear7;
    logic         in_valid7;
    logic [15:0]  in_act7;
    logic         out_valid7;
    logic         frame_done7;
    logic [783:0] out_act7 [1];

    int n_checks = 0;
    int n_fail   = 0;

    logic        ov, ofd;
    logic [31:0] oa0, oa1;

    localparam logic [31:0] EXP0 [4] = '{
        32'h05040100, 32'h07060302,
        32'h0D0C0908, 32'h0F0E0B0A
    };
    localparam logic [31:0] OFS = 32'h64646464;

    always #5 clk = ~clk;

    pool_window_buffer #(
        .NBITS(8), .NFMAPS(2), .KER_SIZE(2), .IMG_W(4), .IMG_H(4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_act     (in_act),
        .out_valid  (out_valid),
        .out_act    (out_act),
        .frame_done (frame_done)
    );

    pool_window_buffer #(
        .NBITS(16), .NFMAPS(1), .KER_SIZE(7), .IMG_W(7), .IMG_H(7)
    ) dut7 (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (clear7),
        .in_valid   (in_valid7),
        .in_act     (in_act7),
        .out_valid  (out_valid7),
        .out_act    (out_act7),
        .frame_done (frame_done7)
    );

    function automatic int win_idx(input int k);
        case (k % 16)
            5:       return 0;
            7:       return 1;
            13:      return 2;
            15:      return 3;
            default: return -1;
        endcase
    endfunction

    task automatic cyc(input logic v, input logic clr, input int k);
        in_valid = v;
        clear    = clr;
        in_act   = {8'(k % 16 + 100), 8'(k % 16)};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        ov  = out_valid;
        ofd = frame_done;
        oa0 = out_act[0];
        oa1 = out_act[1];
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got v=%b fd=%b want 0 0",
                     out_valid, frame_done);
        end
        n_checks++;
        if (out_act[0] !== 32'h0 || out_act[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_act: got %h %h want 0 0",
                     out_act[0], out_act[1]);
        end
        n_checks++;
        if (out_valid7 !== 1'b0 || out_act7[0] !== '0) begin
            n_fail++;
            $display("FAIL reset_k7: got v=%b act nonzero=%b want 0 0",
                     out_valid7, |out_act7[0]);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int w;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b0, k);
            w = win_idx(k);
            n_checks++;
            if (ov !== (w >= 0)) begin
                n_fail++;
                $display("FAIL basic_valid beat %0d: got %b want %b",
                         k + 1, ov, w >= 0);
            end
            n_checks++;
            if (ofd !== (k == 15)) begin
                n_fail++;
                $display("FAIL basic_done beat %0d: got %b want %b",
                         k + 1, ofd, k == 15);
            end
            if (w >= 0) begin
                n_checks++;
                if (oa0 !== EXP0[w] || oa1 !== EXP0[w] + OFS) begin
                    n_fail++;
                    $display("FAIL basic_win%0d: got %h %h want %h %h",
                             w, oa0, oa1, EXP0[w], EXP0[w] + OFS);
                end
            end
            if (k == 6) begin
                n_checks++;
                if (oa0 !== EXP0[0]) begin
                    n_fail++;
                    $display("FAIL basic_hold: got %h want %h",
                             oa0, EXP0[0]);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        int w;
        logic [31:0] last;
        last = EXP0[3];
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b0, k);
            w = win_idx(k);
            n_checks++;
            if (ov !== (w >= 0) || ofd !== (k == 15)) begin
                n_fail++;
                $display("FAIL bub_valid beat %0d: got v=%b fd=%b want %b %b",
                         k + 1, ov, ofd, w >= 0, k == 15);
            end
            if (w >= 0) begin
                last = EXP0[w];
                n_checks++;
                if (oa0 !== EXP0[w] || oa1 !== EXP0[w] + OFS) begin
                    n_fail++;
                    $display("FAIL bub_win%0d: got %h %h want %h %h",
                             w, oa0, oa1, EXP0[w], EXP0[w] + OFS);
                end
            end
            cyc(1'b0, 1'b0, 99);
            n_checks++;
            if (ov !== 1'b0 || ofd !== 1'b0 || oa0 !== last) begin
                n_fail++;
                $display("FAIL bub_gap beat %0d: got v=%b fd=%b %h want 0 0 %h",
                         k + 1, ov, ofd, oa0, last);
            end
        end
    endtask

    task automatic test_back_to_back();
        int w, nwin, nfd;
        nwin = 0;
        nfd  = 0;
        for (int k = 0; k < 32; k++) begin
            cyc(1'b1, 1'b0, k);
            w = win_idx(k);
            if (ov === 1'b1) nwin++;
            if (ofd === 1'b1) nfd++;
            n_checks++;
            if (ov !== (w >= 0)) begin
                n_fail++;
                $display("FAIL b2b_valid beat %0d: got %b want %b",
                         k + 1, ov, w >= 0);
            end
            if (w >= 0) begin
                n_checks++;
                if (oa0 !== EXP0[w] || oa1 !== EXP0[w] + OFS) begin
                    n_fail++;
                    $display("FAIL b2b_win beat %0d: got %h %h want %h %h",
                             k + 1, oa0, oa1, EXP0[w], EXP0[w] + OFS);
                end
            end
        end
        n_checks++;
        if (nwin != 8 || nfd != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: got win=%0d fd=%0d want 8 2",
                     nwin, nfd);
        end
    endtask

    task automatic test_clear();
        int w;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0, k);
        end
        n_checks++;
        if (ov !== 1'b1 || oa0 !== EXP0[0]) begin
            n_fail++;
            $display("FAIL clr_pre: got v=%b %h want 1 %h",
                     ov, oa0, EXP0[0]);
        end
        cyc(1'b1, 1'b1, 6);
        n_checks++;
        if (ov !== 1'b0 || ofd !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_flags: got v=%b fd=%b want 0 0", ov, ofd);
        end
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b0, k);
            w = win_idx(k);
            n_checks++;
            if (ov !== (w >= 0) || ofd !== (k == 15)) begin
                n_fail++;
                $display("FAIL clr_valid beat %0d: got v=%b fd=%b want %b %b",
                         k + 1, ov, ofd, w >= 0, k == 15);
            end
            if (w >= 0) begin
                n_checks++;
                if (oa0 !== EXP0[w] || oa1 !== EXP0[w] + OFS) begin
                    n_fail++;
                    $display("FAIL clr_win%0d: got %h %h want %h %h",
                             w, oa0, oa1, EXP0[w], EXP0[w] + OFS);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int w;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0, k);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_flags: got v=%b fd=%b want 0 0",
                     out_valid, frame_done);
        end
        n_checks++;
        if (out_act[0] !== 32'h0 || out_act[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL arst_act: got %h %h want 0 0",
                     out_act[0], out_act[1]);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b0, k);
            w = win_idx(k);
            n_checks++;
            if (ov !== (w >= 0) || ofd !== (k == 15)) begin
                n_fail++;
                $display("FAIL arst_valid beat %0d: got v=%b fd=%b want %b %b",
                         k + 1, ov, ofd, w >= 0, k == 15);
            end
            if (w >= 0) begin
                n_checks++;
                if (oa0 !== EXP0[w] || oa1 !== EXP0[w] + OFS) begin
                    n_fail++;
                    $display("FAIL arst_win%0d: got %h %h want %h %h",
                             w, oa0, oa1, EXP0[w], EXP0[w] + OFS);
                end
            end
        end
    endtask

    task automatic test_k7();
        logic [783:0] e7;
        int nv;
        nv = 0;
        for (int e = 0; e < 49; e++) begin
            e7[e*16 +: 16] = 16'(e);
        end
        for (int k = 0; k < 49; k++) begin
            in_valid7 = 1'b1;
            in_act7   = 16'(k);
            @(posedge clk);
            #1;
            in_valid7 = 1'b0;
            if (out_valid7 === 1'b1) nv++;
            if (k == 48) begin
                n_checks++;
                if (out_valid7 !== 1'b1 || frame_done7 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL k7_flags: got v=%b fd=%b want 1 1",
                             out_valid7, frame_done7);
                end
                n_checks++;
                if (out_act7[0] !== e7) begin
                    n_fail++;
                    $display("FAIL k7_win: e0=%0d e24=%0d e48=%0d want 0 24 48",
                             out_act7[0][15:0], out_act7[0][399:384],
                             out_act7[0][783:768]);
                end
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (nv != 1 || out_valid7 !== 1'b0) begin
            n_fail++;
            $display("FAIL k7_pulse: got count=%0d v_after=%b want 1 0",
                     nv, out_valid7);
        end
    endtask

    initial begin
        rstn      = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_act    = '0;
        clear7    = 1'b0;
        in_valid7 = 1'b0;
        in_act7   = '0;
        test_reset();
        test_basic();
        test_bubbles();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_k7();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
